// File: rtl/dcache_refill_if.sv
// Beat-serial memory bus between the data-cache refill controller (master)
// and the memory side (slave): request channel, write-beat channel, read-beat channel.
interface dcache_refill_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: stalls the pipeline, writes back a dirty victim, fills the block.
// Define DCACHE_REFILL_PERF_CNT_EN to enable the miss / write-back performance counters.
module dcache_refill_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SET_WIDTH  = 512
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  mem_access_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  hit_i,
  input  logic                  dirty_i,
  input  logic [ADDR_WIDTH-1:0] addr_wb_i,
  input  logic [SET_WIDTH-1:0]  data_block_i,
  output logic                  stall_o,
  output logic                  block_we_o,
  output logic [SET_WIDTH-1:0]  data_block_o,
  dcache_refill_if.master       mem,
  output logic [31:0]           miss_cnt_o,
  output logic [31:0]           wb_cnt_o
);
  localparam int BEATS   = SET_WIDTH / DATA_WIDTH;
  localparam int BLK_OFF = $clog2(SET_WIDTH / 8);
  localparam int BW      = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, REFILL} state_t;

  state_t                               state_q, state_d;
  logic [BW-1:0]                        beat_q;
  logic [ADDR_WIDTH-1:0]                wb_addr_q;
  logic [BEATS-1:0][DATA_WIDTH-1:0]     line_q;
  logic                                 miss;
  logic                                 unused_addr_off;

  assign miss            = mem_access_i & ~hit_i;
  assign unused_addr_off = ^addr_i[BLK_OFF-1:0];

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Every handshake output is a pure decode of state_q; only stall_o in IDLE
  // and the fill address look at pipeline inputs.
  always_comb begin
    state_d         = state_q;
    stall_o         = 1'b1;
    block_we_o      = 1'b0;
    data_block_o    = '0;
    mem.req_valid   = 1'b0;
    mem.req_write   = 1'b0;
    mem.req_addr    = '0;
    mem.wdata_valid = 1'b0;
    mem.wdata       = '0;
    mem.rdata_ready = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = miss;
        if (miss) state_d = dirty_i ? WB_REQ : FILL_REQ;
      end
      WB_REQ: begin
        mem.req_valid = 1'b1;
        mem.req_write = 1'b1;
        mem.req_addr  = wb_addr_q;
        if (mem.req_ready) state_d = WB_DATA;
      end
      WB_DATA: begin
        mem.wdata_valid = 1'b1;
        mem.wdata       = line_q[beat_q];
        if (mem.wdata_ready && beat_q == LAST_BEAT) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        mem.req_valid = 1'b1;
        mem.req_addr  = {addr_i[ADDR_WIDTH-1:BLK_OFF], {BLK_OFF{1'b0}}};
        if (mem.req_ready) state_d = FILL_DATA;
      end
      FILL_DATA: begin
        mem.rdata_ready = 1'b1;
        if (mem.rdata_valid && beat_q == LAST_BEAT) state_d = REFILL;
      end
      REFILL: begin
        block_we_o   = 1'b1;
        data_block_o = line_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One line buffer serves both directions: victim on the way out, fill on the way in.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      line_q    <= '0;
      wb_addr_q <= '0;
      beat_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (miss && dirty_i) begin
          line_q    <= data_block_i;
          wb_addr_q <= addr_wb_i;
        end
        WB_REQ, FILL_REQ: if (mem.req_ready) beat_q <= '0;
        WB_DATA: if (mem.wdata_ready) beat_q <= beat_q + 1'b1;
        FILL_DATA: if (mem.rdata_valid) begin
          line_q[beat_q] <= mem.rdata;
          beat_q         <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_REFILL_PERF_CNT_EN
  logic [31:0] miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (state_q == IDLE && miss) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
      if (dirty_i) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`else
  assign miss_cnt_o = '0;
  assign wb_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Bench for dcache_refill_ctrl: a reactive memory responder with planned wait counts,
// a transaction-level expectation model, and a per-cycle compare process.
module tb_dcache_refill_ctrl;
  localparam int AW = 64, DW = 64, SW = 512, BEATS = 8;
`ifdef DCACHE_REFILL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {logic wr; logic [AW-1:0] addr;} req_t;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          mem_access_i, hit_i, dirty_i;
  logic [AW-1:0] addr_i, addr_wb_i;
  logic [SW-1:0] data_block_i;
  logic          stall_o, block_we_o;
  logic [SW-1:0] data_block_o;
  logic [31:0]   miss_cnt_o, wb_cnt_o;

  dcache_refill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  dcache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SET_WIDTH(SW)) dut (
    .clk_i(clk), .arst_i(arst_i), .mem_access_i(mem_access_i), .addr_i(addr_i),
    .hit_i(hit_i), .dirty_i(dirty_i), .addr_wb_i(addr_wb_i), .data_block_i(data_block_i),
    .stall_o(stall_o), .block_we_o(block_we_o), .data_block_o(data_block_o),
    .mem(mif), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // planned memory behaviour for the current transaction
  int          w_wreq, w_freq;
  int          w_wb [BEATS];
  int          w_rb [BEATS];
  logic [DW-1:0] fill_beats [BEATS];

  // expectation model
  bit          in_rst, tx_on;
  int          t0, t_ref;
  req_t        exp_req_q [$];
  logic [DW-1:0] exp_wb_q [$];
  logic [SW-1:0] exp_block;
  logic [31:0] n_miss, n_wb;

  // observations for hand-computed checks
  logic [AW-1:0] obs_fill_addr, obs_wb_addr;
  logic [DW-1:0] obs_wfirst, obs_wlast;
  int          we_cyc, stall_cnt;

  int n_chk = 0, n_pass = 0;

  task automatic chkw(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chkw(nm, SW'(act), SW'(exp));
  endtask

  function automatic logic [SW-1:0] rnd_blk();
    logic [SW-1:0] r;
    for (int k = 0; k < SW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int total_wait(input bit dirty);
    int s = w_freq;
    for (int k = 0; k < BEATS; k++) s += w_rb[k];
    if (dirty) begin
      s += w_wreq;
      for (int k = 0; k < BEATS; k++) s += w_wb[k];
    end
    return s;
  endfunction

  task automatic set_waits(input int maxw);
    w_wreq = $urandom_range(0, maxw);
    w_freq = $urandom_range(0, maxw);
    for (int k = 0; k < BEATS; k++) begin
      w_wb[k] = $urandom_range(0, maxw);
      w_rb[k] = $urandom_range(0, maxw);
      fill_beats[k] = {$urandom, $urandom};
    end
  endtask

  // Memory slave: once the controller presents a handshake, hold our side low
  // for the planned number of cycles, then complete it. Noise elsewhere.
  task automatic mem_loop();
    int wcnt = 0, wbi = 0, rbi = 0, need;
    forever begin
      @(posedge clk); #1;
      if (in_rst) begin
        mif.req_ready = 1'b0; mif.wdata_ready = 1'b0; mif.rdata_valid = 1'b0; mif.rdata = '0;
        wcnt = 0; wbi = 0; rbi = 0;
      end else begin
        if (mif.req_valid) begin
          need = mif.req_write ? w_wreq : w_freq;
          mif.req_ready = (wcnt >= need);
          if (mif.req_ready) begin
            wcnt = 0;
            if (mif.req_write) wbi = 0; else rbi = 0;
          end else wcnt++;
        end else mif.req_ready = 1'($urandom_range(0, 1));
        if (mif.wdata_valid) begin
          need = (wbi < BEATS) ? w_wb[wbi] : 0;
          mif.wdata_ready = (wcnt >= need);
          if (mif.wdata_ready) begin wcnt = 0; wbi++; end else wcnt++;
        end else mif.wdata_ready = 1'($urandom_range(0, 1));
        if (mif.rdata_ready) begin
          need = (rbi < BEATS) ? w_rb[rbi] : 0;
          mif.rdata_valid = (wcnt >= need);
          mif.rdata = (rbi < BEATS) ? fill_beats[rbi] : {$urandom, $urandom};
          if (mif.rdata_valid) begin wcnt = 0; rbi++; end else wcnt++;
        end else begin
          mif.rdata_valid = 1'($urandom_range(0, 1));
          mif.rdata = {$urandom, $urandom};
        end
      end
    end
  endtask

  task automatic compare_loop();
    bit pend = 0;
    req_t preq, want;
    logic [DW-1:0] wexp;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_block_we", block_we_o, 1'b0);
        chk1("rst_req_valid", mif.req_valid, 1'b0);
        pend = 0;
      end else begin
        chk1("stall", stall_o, (tx_on && cyc >= t0 && cyc <= t_ref) || (mem_access_i && !hit_i));
        chk1("block_we", block_we_o, tx_on && cyc == t_ref);
        if (block_we_o) begin
          chkw("block", data_block_o, exp_block);
          chkw("miss_cnt", SW'(miss_cnt_o), SW'(PERF ? n_miss : 32'd0));
          chkw("wb_cnt", SW'(wb_cnt_o), SW'(PERF ? n_wb : 32'd0));
          we_cyc = cyc - t0;
        end
        if (stall_o) stall_cnt++;
        if (pend)
          chkw("req_hold", SW'({mif.req_valid, mif.req_write, mif.req_addr}),
               SW'({1'b1, preq.wr, preq.addr}));
        if (mif.req_valid && mif.req_ready) begin
          if (exp_req_q.size() == 0) chk1("req_unexpected", mif.req_valid, 1'b0);
          else begin
            want = exp_req_q.pop_front();
            chkw("req", SW'({mif.req_write, mif.req_addr}), SW'({want.wr, want.addr}));
            if (mif.req_write) obs_wb_addr = mif.req_addr; else obs_fill_addr = mif.req_addr;
          end
        end
        pend = mif.req_valid && !mif.req_ready;
        preq = '{wr: mif.req_write, addr: mif.req_addr};
        if (mif.wdata_valid && mif.wdata_ready) begin
          if (exp_wb_q.size() == 0) chk1("wdata_unexpected", mif.wdata_valid, 1'b0);
          else begin
            wexp = exp_wb_q.pop_front();
            chkw("wdata", SW'(mif.wdata), SW'(wexp));
            if (exp_wb_q.size() == BEATS - 1) obs_wfirst = mif.wdata;
            obs_wlast = mif.wdata;
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    in_rst = 1'b1; arst_i = 1'b0; mem_access_i = 1'b0; hit_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tx_on = 1'b0; exp_req_q.delete(); exp_wb_q.delete(); n_miss = 0; n_wb = 0;
    arst_i = 1'b1; in_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      mem_access_i = 1'($urandom_range(0, 1));
      hit_i = mem_access_i ? 1'b1 : 1'($urandom_range(0, 1));
      addr_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    mem_access_i = 1'b0; hit_i = 1'b0;
  endtask

  // Expected refill cycle: detect + (write-back 1+BEATS) + fill request + BEATS + waits.
  task automatic do_miss(input bit dirty, input logic [AW-1:0] a, input logic [AW-1:0] wba,
                         input logic [SW-1:0] vblk, input int abort_at);
    t0 = cyc;
    t_ref = cyc + 10 + (dirty ? 9 : 0) + total_wait(dirty);
    exp_req_q.delete(); exp_wb_q.delete();
    if (dirty) begin
      exp_req_q.push_back('{wr: 1'b1, addr: wba});
      for (int k = 0; k < BEATS; k++) exp_wb_q.push_back(vblk[k*DW +: DW]);
    end
    exp_req_q.push_back('{wr: 1'b0, addr: a & ~64'h3f});
    for (int k = 0; k < BEATS; k++) exp_block[k*DW +: DW] = fill_beats[k];
    n_miss++;
    if (dirty) n_wb++;
    stall_cnt = 0; we_cyc = -1;
    tx_on = 1'b1;
    addr_i = a; mem_access_i = 1'b1; hit_i = 1'b0; dirty_i = dirty;
    addr_wb_i = wba; data_block_i = vblk;
    @(posedge clk); #1;
    while (cyc <= t_ref) begin
      if (abort_at >= 0 && cyc == t0 + abort_at) begin
        apply_reset();
        return;
      end
      mem_access_i = 1'($urandom_range(0, 1)); hit_i = 1'($urandom_range(0, 1));
      dirty_i = 1'($urandom_range(0, 1)); addr_wb_i = {$urandom, $urandom};
      data_block_i = rnd_blk();
      @(posedge clk); #1;
    end
    mem_access_i = 1'b1; hit_i = 1'b1;  // the access now hits
    @(posedge clk); #1;
    mem_access_i = 1'b0; hit_i = 1'b0; tx_on = 1'b0;
  endtask

  task automatic zero_waits();
    w_wreq = 0; w_freq = 0;
    for (int k = 0; k < BEATS; k++) begin w_wb[k] = 0; w_rb[k] = 0; end
  endtask

  initial begin
    logic [SW-1:0] vblk;
    in_rst = 1'b1; tx_on = 1'b0; arst_i = 1'b0; n_miss = 0; n_wb = 0;
    mem_access_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0; addr_i = '0; addr_wb_i = '0;
    data_block_i = '0;
    mif.req_ready = 1'b0; mif.wdata_ready = 1'b0; mif.rdata_valid = 1'b0; mif.rdata = '0;
    zero_waits();
    for (int k = 0; k < BEATS; k++) fill_beats[k] = '0;
    fork
      mem_loop();
      compare_loop();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) begin @(posedge clk); #1; end
    chk1("reset_stall", stall_o, 1'b0);
    chk1("reset_block_we", block_we_o, 1'b0);
    chk1("reset_req_valid", mif.req_valid, 1'b0);
    chkw("reset_miss_cnt", SW'(miss_cnt_o), SW'(32'd0));
    chkw("reset_wb_cnt", SW'(wb_cnt_o), SW'(32'd0));
    arst_i = 1'b1; in_rst = 1'b0;
    idle(4);

    // clean miss, zero-wait memory, beats 0..7
    zero_waits();
    for (int k = 0; k < BEATS; k++) fill_beats[k] = 64'(k);
    do_miss(1'b0, 64'h1234, 64'h0, '0, -1);
    chkw("clean_fill_addr", SW'(obs_fill_addr), SW'(64'h1200));
    chkw("clean_we_cycle", SW'(we_cyc), SW'(10));
    chkw("clean_stall_cycles", SW'(stall_cnt), SW'(11));
    chkw("clean_low_beat", SW'(exp_block[63:0]), SW'(data_block_o_last_low()));
    idle(3);

    // dirty miss, victim beats 0xA0+k
    zero_waits();
    for (int k = 0; k < BEATS; k++) begin
      vblk[k*DW +: DW] = 64'(8'hA0 + k);
      fill_beats[k] = {$urandom, $urandom};
    end
    do_miss(1'b1, 64'h4567, 64'h8000, vblk, -1);
    chkw("dirty_wb_addr", SW'(obs_wb_addr), SW'(64'h8000));
    chkw("dirty_wdata_first", SW'(obs_wfirst), SW'(64'hA0));
    chkw("dirty_wdata_last", SW'(obs_wlast), SW'(64'hA7));
    chkw("dirty_fill_addr", SW'(obs_fill_addr), SW'(64'h4540));
    chkw("dirty_stall_cycles", SW'(stall_cnt), SW'(20));
    idle(2);

    // fill request held off for 5 cycles
    zero_waits(); w_freq = 5;
    do_miss(1'b0, 64'hFFC0_0010, 64'h0, '0, -1);
    chkw("freq_wait_we_cycle", SW'(we_cyc), SW'(15));
    chkw("freq_wait_stall_cycles", SW'(stall_cnt), SW'(16));
    idle(2);

    // read beats arriving every other cycle
    zero_waits();
    for (int k = 1; k < BEATS; k++) w_rb[k] = 1;
    for (int k = 0; k < BEATS; k++) fill_beats[k] = 64'h1111_0000 + 64'(k);
    do_miss(1'b0, 64'h2000, 64'h0, '0, -1);
    chkw("toggle_we_cycle", SW'(we_cyc), SW'(17));
    idle(2);

    // reset while FILL_DATA is on beat 3, then a fresh miss restarts at beat 0
    zero_waits();
    do_miss(1'b0, 64'hABC0, 64'h0, '0, 5);
    chk1("post_rst_stall", stall_o, 1'b0);
    chk1("post_rst_req_valid", mif.req_valid, 1'b0);
    for (int k = 0; k < BEATS; k++) fill_beats[k] = 64'h5500 + 64'(k);
    do_miss(1'b0, 64'h3040, 64'h0, '0, -1);
    chkw("restart_we_cycle", SW'(we_cyc), SW'(10));
    idle(2);

    // performance counters: 3 clean, 2 dirty after a reset
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_waits(2);
      do_miss(i >= 3, {$urandom, $urandom}, {$urandom, $urandom}, rnd_blk(), -1);
      idle(1);
    end
    chkw("perf_miss_cnt", SW'(miss_cnt_o), SW'(PERF ? 32'd5 : 32'd0));
    chkw("perf_wb_cnt", SW'(wb_cnt_o), SW'(PERF ? 32'd2 : 32'd0));

    // random traffic
    for (int i = 0; i < 40; i++) begin
      set_waits(($urandom_range(0, 3) == 0) ? 0 : 3);
      do_miss(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
              rnd_blk(), -1);
      idle($urandom_range(0, 3));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // low beat of the most recent clean-miss fill as planned (beat 0 = 0)
  function automatic logic [63:0] data_block_o_last_low();
    return fill_beats[0];
  endfunction
endmodule

// File: doc/dcache_refill_ctrl.md
# dcache_refill_ctrl

Miss-handling controller for the data cache, sitting between the cache and a beat-serial memory bus. On a miss it stalls the pipeline and, if the victim line is dirty, writes it back. It then fetches the missing block and writes it into the cache. It drives the cache's block write enable and block data inputs, and consumes the cache's hit, dirty, write-back address and write-back block outputs.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, memory bus beat width.
- SET_WIDTH, 512, cache block width in bits.
- Derived: BEATS = SET_WIDTH/DATA_WIDTH = 8; BLK_OFF = $clog2(SET_WIDTH/8) = 6.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  one clock; reset is asynchronous and active-low.
- mem_access_i  in  1  pipeline load or store to the cache this cycle.
- addr_i  in  ADDR_WIDTH  pipeline access address; held stable while stall_o=1.
- hit_i  in  1  cache hit.
- dirty_i  in  1  victim line dirty.
- addr_wb_i  in  ADDR_WIDTH  victim block address.
- data_block_i  in  SET_WIDTH  victim block data.
- stall_o  out  1  pipeline stall.
- block_we_o  out  1  cache block write enable (one-cycle pulse).
- data_block_o  out  SET_WIDTH  refill block to the cache.
- req_valid_o / req_ready_i  out/in  1  request handshake.
- req_write_o  out  1  1 = write-back request, 0 = fill request.
- req_addr_o  out  ADDR_WIDTH  block-aligned request address.
- wdata_valid_o / wdata_ready_i  out/in  1  write beat handshake.
- wdata_o  out  DATA_WIDTH  write beat.
- rdata_valid_i  in  1  read beat valid.
- rdata_ready_o  out  1  read beat ready.
- rdata_i  in  DATA_WIDTH  read beat.
- miss_cnt_o, wb_cnt_o  out  32  performance counters (see Configuration).

## Operation
States: IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, REFILL.

- **IDLE**
  - stall_o = mem_access_i & ~hit_i (combinational).
  - On a miss with dirty_i=1: capture addr_wb_i and data_block_i into the line buffer, go to WB_REQ.
  - On a miss with dirty_i=0: go to FILL_REQ.
- **WB_REQ**
  - Outputs: req_valid_o=1, req_write_o=1, req_addr_o = captured victim address.
  - On req_ready_i: go to WB_DATA, beat counter = 0.
- **WB_DATA**
  - Outputs: wdata_valid_o=1, wdata_o = buf[beat*DATA_WIDTH +: DATA_WIDTH]; the low beat is sent first.
  - Each wdata_ready_i increments the beat counter.
  - Acceptance of beat BEATS-1: go to FILL_REQ.
- **FILL_REQ**
  - Outputs: req_valid_o=1, req_write_o=0, req_addr_o = {addr_i[ADDR_WIDTH-1:BLK_OFF], BLK_OFF'b0}.
  - On req_ready_i: go to FILL_DATA, beat counter = 0.
- **FILL_DATA**
  - Output: rdata_ready_o=1.
  - Each rdata_valid_i writes rdata_i into buf[beat] and increments the beat counter.
  - Beat BEATS-1 received: go to REFILL.
- **REFILL**
  - Outputs: block_we_o=1, data_block_o = buf, for exactly one cycle; then go to IDLE.
- stall_o=1 in every non-IDLE state.
- Counters:
  - The beat counter is $clog2(BEATS) bits and is cleared on entry to each data state.
  - miss_cnt_o and wb_cnt_o wrap modulo 2^32.

Boundary rules:
- req_valid_o, req_addr_o and req_write_o stay stable until req_ready_i is seen; a request is never withdrawn.
- mem_access_i deasserting mid-transaction is ignored; the transaction completes.
- rdata_valid_i outside FILL_DATA is ignored; wdata_ready_i outside WB_DATA is ignored.
- Store misses take the same path. The cache performs the store on the hit in the cycle after REFILL.
- Reset mid-transaction:
  - Return to IDLE; clear the buffer and beat counter; all outputs 0.
  - The memory side must also be reset; partial transfers are abandoned.

## Timing
- All outputs reset to 0; the state resets to IDLE.
- Clean miss, zero-wait memory:
  - Cycle 0: detect (IDLE).
  - Cycle 1: FILL_REQ.
  - Cycles 2–9: FILL_DATA.
  - Cycle 10: REFILL.
  - Cycle 11: IDLE with hit; stall_o=0.
- Dirty miss: adds 1 + BEATS cycles (WB_REQ + WB_DATA) before FILL_REQ, giving 20 stall cycles.
- Each wait cycle on req_ready_i, wdata_ready_i or rdata_valid_i adds one cycle.
- All handshake outputs are registered-state decodes; no output depends combinationally on a ready/valid input.

## Configuration
- DCACHE_REFILL_PERF_CNT_EN defined:
  - miss_cnt_o increments on every IDLE→(WB_REQ|FILL_REQ) transition.
  - wb_cnt_o increments on every IDLE→WB_REQ transition.
- Undefined: both counters are absent and both outputs are tied to 0.

## Test plan
- Reset with arst_i=0 mid-FILL_DATA (beat 3), then release → state IDLE; block_we_o, stall_o and req_valid_o are 0; the next miss restarts at beat 0.
- Clean miss at addr_i=0x1234, zero-wait memory returning beats 0x0..0x7 → req_addr_o=0x1200 with req_write_o=0; block_we_o pulses in cycle 10; data_block_o[63:0]=0, [511:448]=7; stall_o high for cycles 0–10.
- Dirty miss, addr_wb_i=0x8000, victim block with beat k = 0xA0+k → write-back request to 0x8000; wdata_o sequence 0xA0..0xA7; then a fill request; stall_o high for 20 cycles.
- req_ready_i held low for 5 cycles in FILL_REQ → req_valid_o and req_addr_o stay stable for all 5 cycles; refill is delayed by exactly 5 cycles.
- rdata_valid_i toggling 1,0,1,0 → exactly 8 accepted beats assembled in order; block_we_o asserted once.
- With DCACHE_REFILL_PERF_CNT_EN: 3 clean misses and 2 dirty misses → miss_cnt_o=5, wb_cnt_o=2. Without it, both outputs read 0.
